// File: rtl/alu_disp_pkg.sv
// rtl/alu_disp_pkg.sv - shared types, segment codes and double-dabble step for the result display
package alu_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_e;

    localparam logic [6:0] SEG_LUT [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // One double-dabble step on {hund,tens,units,bin}: correct each BCD nibble, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] sr);
        logic [19:0] t;
        t = sr;
        for (int n = 0; n < 3; n++) begin
            if (t[8+4*n +: 4] >= 4'd5) begin
                t[8+4*n +: 4] = t[8+4*n +: 4] + 4'd3;
            end
        end
        return {t[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD digit to active-high 7-segment code with blanking
module bcd_to_seg
    import alu_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else if (bcd_i <= 4'd9) begin
            seg_o = SEG_LUT[bcd_i];
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result to 3-digit BCD via double-dabble, multiplexed 7-seg scan
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50_000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] result,
    output logic [6:0] seg,
    output logic [2:0] digit_en,
    output logic       busy,
    output logic       valid
);

    localparam int                SCAN_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    state_e            state_q, state_d;
    logic [7:0]        held_q, held_d;
    logic [19:0]       sr_q, sr_d;
    logic [2:0]        bit_q, bit_d;
    logic [11:0]       disp_q, disp_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [SCAN_W-1:0] scan_q, scan_d;
    logic [1:0]        idx_q, idx_d;
    logic [2:0]        den_q, den_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        nib_d;
    logic              blank_d;

    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        sr_d    = sr_q;
        bit_d   = bit_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (result != held_q) begin
                    held_d  = result;
                    sr_d    = {12'b0, result};
                    bit_d   = 3'd0;
                    busy_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = dd_step(sr_q);
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = sr_q[19:8];
                busy_d  = 1'b0;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == SCAN_LAST) begin
            scan_d = '0;
            idx_d  = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
    end

    // seg is derived from next-state digits/index so it always matches the registered digit_en.
    always_comb begin
        den_d = 3'b001 << idx_d;
        case (idx_d)
            2'd0:    nib_d = disp_d[3:0];
            2'd1:    nib_d = disp_d[7:4];
            default: nib_d = disp_d[11:8];
        endcase
        blank_d = BLANK_LZ && (((idx_d == 2'd2) && (disp_d[11:8] == 4'd0)) ||
                               ((idx_d == 2'd1) && (disp_d[11:4] == 8'd0)));
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd_i   (nib_d),
        .blank_i (blank_d),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            held_q  <= '0;
            sr_q    <= '0;
            bit_q   <= '0;
            disp_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            scan_q  <= '0;
            idx_q   <= '0;
            den_q   <= 3'b001;
            seg_q   <= SEG_LUT[0];
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            sr_q    <= sr_d;
            bit_q   <= bit_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            den_q   <= den_d;
            seg_q   <= seg_d;
        end
    end

    assign seg      = seg_q;
    assign digit_en = den_q;
    assign busy     = busy_q;
    assign valid    = valid_q;

endmodule

// File: tb/tb_alu_result_display.sv
// tb/tb_alu_result_display.sv - randomized and directed checks of alu_result_display against a decimal model
module tb_alu_result_display;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst;
    logic [7:0] result;
    logic [6:0] seg,   seg_nb;
    logic [2:0] digit_en, digit_en_nb;
    logic       busy,  busy_nb;
    logic       valid, valid_nb;

    int n_checks = 0;
    int n_errors = 0;

    logic [6:0] lut [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    alu_result_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .seg      (seg),
        .digit_en (digit_en),
        .busy     (busy),
        .valid    (valid)
    );

    alu_result_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b0)) dut_nb (
        .clk      (clk),
        .rst      (rst),
        .result   (result),
        .seg      (seg_nb),
        .digit_en (digit_en_nb),
        .busy     (busy_nb),
        .valid    (valid_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: a capture starts a 9-edge countdown, then the held value is shown.
    int m_held, m_left, m_disp, m_scan, m_idx;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_held <= 0;
            m_left <= 0;
            m_disp <= 0;
            m_scan <= 0;
            m_idx  <= 0;
        end else begin
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) m_disp <= m_held;
            end else if (int'(result) != m_held) begin
                m_held <= int'(result);
                m_left <= 9;
            end
            if (m_scan == SCAN_DIV - 1) begin
                m_scan <= 0;
                m_idx  <= (m_idx + 1) % 3;
            end else begin
                m_scan <= m_scan + 1;
            end
        end
    end

    function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blz);
        int h, t, u, d;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        d = (idx == 0) ? u : (idx == 1) ? t : h;
        if (blz && ((idx == 2 && h == 0) || (idx == 1 && v < 10))) return 7'h00;
        return lut[d];
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        result = 8'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (seg !== 7'h3F || digit_en !== 3'b001 || busy !== 1'b0 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_hold: seg=%h en=%b busy=%b valid=%b, want 3f 001 0 1", seg, digit_en, busy, valid);
        end
        rst = 1'b0;
        result = 8'd9;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (seg !== 7'h3F || digit_en !== 3'b001 || busy !== 1'b0 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_async: seg=%h en=%b busy=%b valid=%b, want 3f 001 0 1", seg, digit_en, busy, valid);
        end
        n_checks++;
        if (seg_nb !== 7'h3F || digit_en_nb !== 3'b001) begin
            n_errors++;
            $display("FAIL reset_async_nb: seg=%h en=%b, want 3f 001", seg_nb, digit_en_nb);
        end
        result = 8'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_max();
        logic [6:0] want;
        @(negedge clk);
        result = 8'd255;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== (k < 9) || valid !== (k == 9)) begin
                n_errors++;
                $display("FAIL max_timing k=%0d: busy=%b valid=%b, want %b %b", k, busy, valid, k < 9, k == 9);
            end
        end
        for (int k = 0; k < 12; k++) begin
            want = (digit_en == 3'b100) ? 7'h5B : 7'h6D;
            n_checks++;
            if (seg !== want || digit_en !== 3'(1 << m_idx)) begin
                n_errors++;
                $display("FAIL max_digits: seg=%h en=%b, want %h %b", seg, digit_en, want, 3'(1 << m_idx));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_blank();
        logic [6:0] want, want_nb;
        result = 8'd7;
        repeat (11) @(negedge clk);
        for (int k = 0; k < 12; k++) begin
            want    = (digit_en == 3'b001) ? 7'h07 : 7'h00;
            want_nb = (digit_en_nb == 3'b001) ? 7'h07 : 7'h3F;
            n_checks++;
            if (seg !== want || seg_nb !== want_nb || valid !== 1'b1) begin
                n_errors++;
                $display("FAIL blank en=%b: seg=%h seg_nb=%h valid=%b, want %h %h 1", digit_en, seg, seg_nb, valid, want, want_nb);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_restart();
        logic [6:0] want;
        result = 8'd100;
        repeat (4) @(negedge clk);
        result = 8'd42;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k == 5) begin
                n_checks++;
                if (valid !== 1'b1 || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL restart_first_load: busy=%b valid=%b, want 0 1", busy, valid);
                end
            end
            if (k == 6) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL restart_reenter: busy=%b, want 1", busy);
                end
            end
            n_checks++;
            if (seg !== exp_seg(m_disp, m_idx, 1'b1) || digit_en !== 3'(1 << m_idx) ||
                busy !== (m_left > 0) || valid !== (m_left == 0)) begin
                n_errors++;
                $display("FAIL restart_model k=%0d: seg=%h en=%b busy=%b valid=%b, want %h %b %b %b", k, seg,
                         digit_en, busy, valid, exp_seg(m_disp, m_idx, 1'b1), 3'(1 << m_idx), m_left > 0, m_left == 0);
            end
        end
        for (int k = 0; k < 12; k++) begin
            want = (digit_en == 3'b001) ? 7'h5B : (digit_en == 3'b010) ? 7'h66 : 7'h00;
            n_checks++;
            if (seg !== want || valid !== 1'b1) begin
                n_errors++;
                $display("FAIL restart_final en=%b: seg=%h valid=%b, want %h 1", digit_en, seg, valid, want);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_scan();
        logic [2:0] prev;
        int         len;
        bit         first;
        prev  = digit_en;
        len   = 0;
        first = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 10) result = 8'd123;
            len++;
            if (digit_en !== prev) begin
                n_checks++;
                if (digit_en !== {prev[1:0], prev[2]}) begin
                    n_errors++;
                    $display("FAIL scan_order: en=%b after %b", digit_en, prev);
                end
                if (!first) begin
                    n_checks++;
                    if (len !== SCAN_DIV) begin
                        n_errors++;
                        $display("FAIL scan_dwell: en=%b held %0d cycles, want %0d", prev, len, SCAN_DIV);
                    end
                end
                first = 1'b0;
                prev  = digit_en;
                len   = 0;
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst = 1'b1;
        result = 8'd0;
        @(negedge clk);
        rst = 1'b0;
        result = 8'd255;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || seg !== 7'h3F || digit_en !== 3'b001 || valid !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_mid: seg=%h en=%b busy=%b valid=%b, want 3f 001 0 1", seg, digit_en, busy, valid);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (busy !== (k < 9) || valid !== (k == 9)) begin
                n_errors++;
                $display("FAIL reset_mid_redo k=%0d: busy=%b valid=%b, want %b %b", k, busy, valid, k < 9, k == 9);
            end
        end
        n_checks++;
        if (seg !== exp_seg(255, m_idx, 1'b1)) begin
            n_errors++;
            $display("FAIL reset_mid_value: seg=%h, want %h", seg, exp_seg(255, m_idx, 1'b1));
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            n_checks++;
            if (seg !== exp_seg(m_disp, m_idx, 1'b1) || digit_en !== 3'(1 << m_idx) ||
                busy !== (m_left > 0) || valid !== (m_left == 0)) begin
                n_errors++;
                $display("FAIL random k=%0d: seg=%h en=%b busy=%b valid=%b, want %h %b %b %b", k, seg, digit_en,
                         busy, valid, exp_seg(m_disp, m_idx, 1'b1), 3'(1 << m_idx), m_left > 0, m_left == 0);
            end
            n_checks++;
            if (seg_nb !== exp_seg(m_disp, m_idx, 1'b0)) begin
                n_errors++;
                $display("FAIL random_nb k=%0d: seg=%h, want %h", k, seg_nb, exp_seg(m_disp, m_idx, 1'b0));
            end
            if ($urandom_range(0, 5) == 0) begin
                result = ($urandom_range(0, 3) == 0) ? 8'(m_held) : 8'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        result = 8'd0;
        test_reset();
        test_max();
        test_blank();
        test_restart();
        test_scan();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
